uart_result_collector: RTL and testbench
========================================

# uart_result_collector

Host-side receiver for the filter's serial result stream. It deserialises 8N1 UART bytes arriving on the filter board's TXD line and reassembles each group of three bytes, most significant byte first, into the 24-bit filter output word. It pulses a valid strobe for each complete word. It sits on the far end of the link from the filter's result serialiser, in bench and loop-back builds, and is the check point for the byte ordering of the result stream.

## Interface
- CLKS_PER_BIT, default 5208: clk cycles per UART bit (50 MHz / 9600 baud). Must be even and ≥ 8.
- GAP_BITS, default 40: maximum idle time between bytes of one frame, in bit periods, before the partial frame is dropped.
- clk  in  1  system clock; the only clock in the block.
- rst_n  in  1  asynchronous, active-low reset.
- rxd  in  1  serial input, idle high; connected to the filter's TXD.
- word  out  24  last complete result; byte0→[23:16], byte1→[15:8], byte2→[7:0].
- word_valid  out  1  one-cycle pulse when `word` is updated.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- sync_err  out  1  one-cycle pulse when a partial frame is dropped on gap timeout.
- byte_idx  out  2  number of bytes of the current frame already received (0..2).

## Operation
- Input path: `rxd` passes through a two-flop synchroniser (`rxd_s`), both flops reset to 1. Edge detection uses `rxd_s` and its one-cycle delayed copy.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a falling edge of `rxd_s`. The bit counter clears on this edge.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If the sample is 0, go to DATA. If it is 1, the start bit was a glitch: return to IDLE with no error and no byte.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, into a shift register.
  - STOP: sample CLKS_PER_BIT cycles after the last data sample.
    - Sample 1: the byte is accepted.
    - Sample 0: pulse `frame_err`, discard the byte, and clear `byte_idx` to 0.
    - In both cases go to IDLE.
  - A new start bit is recognised only after `rxd_s` has been high for at least one cycle.
- Frame assembler, on each accepted byte:
  - idx 0: latch the byte to hold[23:16]; idx becomes 1.
  - idx 1: latch the byte to hold[15:8]; idx becomes 2.
  - idx 2: load `word` with {hold[23:8], byte}, pulse `word_valid`, and set idx to 0.
- `word` changes only on a `word_valid` cycle. It holds its value across errors.
- Gap timer:
  - Counts clocks while the FSM is in IDLE and idx ≠ 0.
  - Clears on every start-edge detection and whenever idx = 0.
  - On reaching GAP_BITS·CLKS_PER_BIT: pulse `sync_err` and clear idx to 0. The partial data is discarded.
- Simultaneous events:
  - A timeout in the same cycle as a start edge is suppressed; the start edge wins.
  - `frame_err` and `word_valid` are mutually exclusive by construction.

## Timing
- Reset values: word = 0, word_valid = 0, frame_err = 0, sync_err = 0, byte_idx = 0, FSM = IDLE, rxd_s = 1.
- Reset asserted mid-byte or mid-frame aborts everything immediately, with no pulses. After release, the block waits for a fresh falling edge.
- Let t0 be the clk edge at which the start edge is detected (the first `rxd_s` = 0 after a 1).
  - Start sample: t0 + CLKS_PER_BIT/2.
  - Data bit k (k = 0..7): t0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
  - Stop sample: t0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- `word_valid` or `frame_err` is high for exactly the one cycle after the stop-sample edge.
- `byte_idx` updates on that same cycle.
- `rxd` to `rxd_s` latency is 2 clk.
- Back-to-back bytes with a full-length stop bit and zero idle time are received without loss.
- Sampling at mid-bit tolerates about ±4 % baud mismatch.

## Test plan
- CLKS_PER_BIT = 16: send 0x12, 0x34, 0x56 back-to-back → one `word_valid` pulse with word = 0x123456 at the stop sample of byte 2 + 1. byte_idx sequence is 1, 2, 0.
- Glitch: drive rxd low for 4 cycles, then high → no byte, no error pulse, byte_idx remains 0.
- Frame error on the second byte: 0xAA, then 0xBB with stop bit = 0, then 0x01, 0x02, 0x03 → `frame_err` pulse once, byte_idx goes to 0, then word = 0x010203 with a single `word_valid`. No word containing 0xAA is produced.
- Gap timeout, GAP_BITS = 4: send 0x7F, then idle 64 + 2 cycles → `sync_err` pulse at exactly 64 idle cycles after FSM re-enters IDLE. Then 0x00, 0x00, 0x38 → word = 0x000038.
- Reset mid-frame: after 0x11 and 0x22, assert rst_n low for 3 cycles mid-third byte → all outputs return to reset values. Next frame 0xFF, 0xFE, 0xFD → word = 0xFFFEFD.
- Two consecutive frames, 0x000001 then 0xFFFFFF, with no idle time → two `word_valid` pulses exactly 30·16 cycles apart, carrying the correct values.

Source files
------------

// File: rtl/uart_result_collector.sv
// uart_result_collector: 8N1 UART receiver that reassembles three bytes,
// most significant first, into a 24-bit result word with a valid strobe.
// A partial frame is dropped when the line stays idle too long between bytes.
module uart_result_collector #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int GAP_BITS     = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  output logic [23:0] word,
  output logic        word_valid,
  output logic        frame_err,
  output logic        sync_err,
  output logic [1:0]  byte_idx
);

  localparam int HALF      = CLKS_PER_BIT / 2;
  localparam int CW        = $clog2(CLKS_PER_BIT);
  localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
  localparam int GW        = $clog2(GAP_LIMIT + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_M1  = GW'(GAP_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic          r_sync1;
  logic          r_rxd_s;
  logic          r_rxd_d;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitn;
  logic [7:0]    r_shift;
  logic [15:0]   r_hold;
  logic [23:0]   r_word;
  logic          r_word_valid;
  logic          r_frame_err;
  logic          r_sync_err;
  logic [1:0]    r_idx;
  logic [GW-1:0] r_gap;

  state_t        w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic [2:0]    w_bitn_next;
  logic [7:0]    w_shift_next;
  logic          w_byte_ok;
  logic          w_stop_bad;
  logic          w_fall;
  logic          w_gap_hit;

  // Falling edge needs a high rxd_s on the previous cycle, so a line that is
  // still low after a bad stop bit cannot trigger a new start.
  assign w_fall = r_rxd_d & ~r_rxd_s;

  // Timeout only fires from IDLE with a partial frame; a start edge wins.
  assign w_gap_hit = (r_state == S_IDLE) && !w_fall && (r_idx != 2'd0) && (r_gap == GAP_M1);

  // Two-flop synchroniser plus one delayed copy for edge detection; idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
      r_rxd_d <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rxd_s <= r_sync1;
      r_rxd_d <= r_rxd_s;
    end
  end

  // Bit FSM state, bit-period counter and data shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bitn  <= w_bitn_next;
      r_shift <= w_shift_next;
    end
  end

  // Next-state logic: half-bit wait to mid start bit, then full-bit steps.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CW'(1);
    w_bitn_next  = r_bitn;
    w_shift_next = r_shift;
    w_byte_ok    = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (w_fall) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_next  = '0;
          w_bitn_next = '0;
          // A high sample here means the low pulse was only a glitch.
          w_state_next = r_rxd_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_next   = '0;
          w_shift_next = {r_rxd_s, r_shift[7:1]};
          w_bitn_next  = r_bitn + 3'd1;
          if (r_bitn == 3'd7) begin
            w_state_next = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_next   = '0;
          w_state_next = S_IDLE;
          w_byte_ok    = r_rxd_s;
          w_stop_bad   = ~r_rxd_s;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Frame assembler: collect bytes MSB first, publish on the third, and drop
  // the partial frame on a bad stop bit or an inter-byte gap timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold       <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_sync_err   <= 1'b0;
      r_idx        <= 2'd0;
    end else begin
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_sync_err   <= 1'b0;
      if (w_byte_ok) begin
        case (r_idx)
          2'd0: begin
            r_hold[15:8] <= r_shift;
            r_idx        <= 2'd1;
          end
          2'd1: begin
            r_hold[7:0] <= r_shift;
            r_idx       <= 2'd2;
          end
          default: begin
            r_word       <= {r_hold, r_shift};
            r_word_valid <= 1'b1;
            r_idx        <= 2'd0;
          end
        endcase
      end else if (w_stop_bad) begin
        r_frame_err <= 1'b1;
        r_idx       <= 2'd0;
      end else if (w_gap_hit) begin
        r_sync_err <= 1'b1;
        r_idx      <= 2'd0;
      end
    end
  end

  // Gap timer: runs only while idle between bytes of a partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap <= '0;
    end else if ((r_state != S_IDLE) || w_fall || (r_idx == 2'd0) || w_gap_hit) begin
      r_gap <= '0;
    end else begin
      r_gap <= r_gap + GW'(1);
    end
  end

  assign word       = r_word;
  assign word_valid = r_word_valid;
  assign frame_err  = r_frame_err;
  assign sync_err   = r_sync_err;
  assign byte_idx   = r_idx;

endmodule

// File: tb/tb_uart_result_collector.sv
// Scoreboard bench for uart_result_collector: stimulus pushes expected
// events, a negedge monitor pops and compares every output pulse.
module tb_uart_result_collector;

  localparam int CPB = 16;
  localparam int GAP = 4;

  logic        clk;
  logic        rst_n;
  logic        rxd;
  logic [23:0] word;
  logic        word_valid;
  logic        frame_err;
  logic        sync_err;
  logic [1:0]  byte_idx;

  uart_result_collector #(
    .CLKS_PER_BIT(CPB),
    .GAP_BITS    (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .word      (word),
    .word_valid(word_valid),
    .frame_err (frame_err),
    .sync_err  (sync_err),
    .byte_idx  (byte_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;  // 0 word, 1 frame_err, 2 sync_err
    logic [23:0] val;
  } ev_t;

  ev_t  sb[$];
  int   wv_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   sync_cyc = 0;
  logic [1:0] prev_idx = 2'd0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [23:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input logic [23:0] val);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d value 0x%06h expected none", kind, val);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.val !== val) begin
        errors++;
        $display("FAIL event: got kind %0d value 0x%06h expected kind %0d value 0x%06h",
                 kind, val, e.kind, e.val);
      end else begin
        $display("ok   event kind %0d value 0x%06h at cycle %0d", kind, val, cyc);
      end
    end
  endtask

  // Monitor: every pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (word_valid) begin
      pop_cmp(0, word);
      wv_cyc.push_back(cyc);
    end
    if (frame_err) pop_cmp(1, 24'h0);
    if (sync_err) begin
      pop_cmp(2, 24'h0);
      sync_cyc = cyc;
    end
    if (prev_idx == 2'd0 && byte_idx == 2'd1) rise_cyc = cyc;
    prev_idx = byte_idx;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_word", {8'h0, word}, 32'h0);
    check("reset_word_valid", {31'h0, word_valid}, 32'h0);
    check("reset_frame_err", {31'h0, frame_err}, 32'h0);
    check("reset_sync_err", {31'h0, sync_err}, 32'h0);
    check("reset_byte_idx", {30'h0, byte_idx}, 32'h0);
    rst_n = 1'b1;
    idle(5);

    // Basic frame, back-to-back bytes.
    expect_ev(0, 24'h123456);
    send_byte(8'h12, 1'b1);
    check("basic_idx_after_b0", {30'h0, byte_idx}, 32'd1);
    send_byte(8'h34, 1'b1);
    check("basic_idx_after_b1", {30'h0, byte_idx}, 32'd2);
    send_byte(8'h56, 1'b1);
    check("basic_idx_after_b2", {30'h0, byte_idx}, 32'd0);
    idle(20);

    // Start-bit glitch: nothing should happen.
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    check("glitch_idx", {30'h0, byte_idx}, 32'd0);

    // Frame error on the second byte drops the partial frame.
    expect_ev(1, 24'h0);
    expect_ev(0, 24'h010203);
    send_byte(8'hAA, 1'b1);
    check("ferr_idx_after_aa", {30'h0, byte_idx}, 32'd1);
    send_byte(8'hBB, 1'b0);
    check("ferr_idx_after_bad", {30'h0, byte_idx}, 32'd0);
    idle(20);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    idle(20);

    // Gap timeout after one byte.
    expect_ev(2, 24'h0);
    expect_ev(0, 24'h000038);
    send_byte(8'h7F, 1'b1);
    idle(66);
    check("gap_idx_after_timeout", {30'h0, byte_idx}, 32'd0);
    check("gap_timeout_cycles", sync_cyc - rise_cyc, 32'd64);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h38, 1'b1);
    idle(20);

    // Reset in the middle of the third byte.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("rst_idx_before", {30'h0, byte_idx}, 32'd2);
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_word", {8'h0, word}, 32'h0);
    check("rst_mid_byte_idx", {30'h0, byte_idx}, 32'h0);
    check("rst_mid_pulses", {29'h0, word_valid, frame_err, sync_err}, 32'h0);
    rst_n = 1'b1;
    idle(20);
    expect_ev(0, 24'hFFFEFD);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFE, 1'b1);
    send_byte(8'hFD, 1'b1);
    idle(20);

    // Two frames with no idle time between them.
    n = wv_cyc.size();
    expect_ev(0, 24'h000001);
    expect_ev(0, 24'hFFFFFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(20);
    if (wv_cyc.size() >= n + 2) begin
      check("frame_spacing", wv_cyc[n+1] - wv_cyc[n], 32'd480);
    end else begin
      checks++;
      errors++;
      $display("FAIL frame_spacing: got %0d word_valid pulses expected 2", wv_cyc.size() - n);
    end

    idle(50);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
